// File: rtl/fpu_cvt_stage.sv
// Two-stage int-to-float conversion pipeline around an external combinational converter.
// Optional saturating output-transfer counter (stat_count) enabled by defining FPU_CVT_STATS_EN.
module fpu_cvt_stage (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic [4:0]  in_tag,
    output logic [31:0] cvt_x,
    input  logic [31:0] cvt_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y,
    output logic [4:0]  out_tag,
`ifdef FPU_CVT_STATS_EN
    output logic [15:0] stat_count,
`endif
    output logic        busy
);

    // S1 holds the raw operand, S2 the converted result.
    logic        v1;
    logic [31:0] s1_x;
    logic [4:0]  s1_tag;
    logic        v2;
    logic [31:0] s2_y;
    logic [4:0]  s2_tag;

    logic adv1;
    logic adv2;
    logic in_fire;
    logic out_fire;

    // NOTE: combinational handshake logic uses continuous assigns, so no path can infer a latch.
    assign adv2     = !v2 || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1 && !flush && rstn;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = v2 && out_ready;

    assign cvt_x     = v1 ? s1_x : 32'h0;
    assign out_valid = v2;
    assign out_y     = s2_y;
    assign out_tag   = s2_tag;
    assign busy      = v1 || v2;

    // NOTE: all state uses non-blocking assignments so S1->S2 and input->S1 move in the same edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            v1     <= 1'b0;
            s1_x   <= 32'h0;
            s1_tag <= 5'h0;
            v2     <= 1'b0;
            s2_y   <= 32'h0;
            s2_tag <= 5'h0;
        end else if (flush) begin
            // Kill validity only; payload registers keep their last contents.
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (adv2) begin
                if (v1) begin
                    s2_y   <= cvt_y;
                    s2_tag <= s1_tag;
                    v2     <= 1'b1;
                end else begin
                    v2 <= 1'b0;
                end
            end
            if (in_fire) begin
                s1_x   <= in_x;
                s1_tag <= in_tag;
                v1     <= 1'b1;
            end else if (adv1) begin
                v1 <= 1'b0;
            end
        end
    end

`ifdef FPU_CVT_STATS_EN
    // Counts every output handshake, flush or not; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_count <= 16'h0;
        end else if (out_fire && stat_count != 16'hFFFF) begin
            stat_count <= stat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_cvt_stage.sv
// Directed self-checking bench for fpu_cvt_stage with a behavioural int-to-float converter.
// Define FPU_CVT_STATS_EN to also exercise stat_count.
module tb_fpu_cvt_stage;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [4:0]  in_tag;
    logic [31:0] cvt_x;
    logic [31:0] cvt_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [4:0]  out_tag;
    logic        busy;
`ifdef FPU_CVT_STATS_EN
    logic [15:0] stat_count;
`endif

    int n_total = 0;
    int n_bad   = 0;

    fpu_cvt_stage dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_tag    (in_tag),
        .cvt_x     (cvt_x),
        .cvt_y     (cvt_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag),
`ifdef FPU_CVT_STATS_EN
        .stat_count(stat_count),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-to-nearest-even int32 -> binary32, standing in for the external converter.
    function automatic logic [31:0] i2f(input logic [31:0] x);
        logic [32:0] a;
        logic [32:0] m;
        logic [32:0] rem;
        logic [32:0] half;
        logic [7:0]  e;
        int          p;
        int          s;
        if (x == 32'h0) return 32'h0;
        a = x[31] ? (33'd0 - {x[31], x}) : {1'b0, x};
        p = 0;
        for (int i = 0; i < 33; i++) if (a[i]) p = i;
        e = 8'(127 + p);
        if (p <= 23) begin
            m = a << (23 - p);
        end else begin
            s    = p - 23;
            m    = a >> s;
            rem  = a & ((33'd1 << s) - 33'd1);
            half = 33'd1 << (s - 1);
            if (rem > half || (rem == half && m[0])) m = m + 33'd1;
            if (m[24]) begin
                m = m >> 1;
                e = e + 8'd1;
            end
        end
        return {x[31], e, m[22:0]};
    endfunction

    assign cvt_y = i2f(cvt_x);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_x     = 32'h0;
        in_tag   = 5'h0;
    endtask

    task automatic offer(input logic [31:0] x, input logic [4:0] t);
        in_valid = 1'b1;
        in_x     = x;
        in_tag   = t;
    endtask

    logic [31:0] vx [6];
    logic [31:0] vy [6];

    initial begin
        rstn      = 1'b0;
        out_ready = 1'b0;
        idle_inputs();

        // Reset state
        step();
        step();
        #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_cvt_x", cvt_x, 32'h0);
        check("rst_out_y", out_y, 32'h0);
        check("rst_out_tag", {27'h0, out_tag}, 32'h0);

        // Single request, two-cycle latency
        step();
        rstn      = 1'b1;
        out_ready = 1'b1;
        offer(32'h00000001, 5'd3);
        #1;
        check("one_in_ready", {31'h0, in_ready}, 32'h1);
        check("one_cvt_x_c0", cvt_x, 32'h0);
        step();
        idle_inputs();
        #1;
        check("one_cvt_x_c1", cvt_x, 32'h00000001);
        check("one_valid_c1", {31'h0, out_valid}, 32'h0);
        check("one_busy_c1", {31'h0, busy}, 32'h1);
        step();
        #1;
        check("one_valid_c2", {31'h0, out_valid}, 32'h1);
        check("one_y", out_y, 32'h3F800000);
        check("one_tag", {27'h0, out_tag}, 32'd3);
        step();
        #1;
        check("one_valid_c3", {31'h0, out_valid}, 32'h0);
        check("one_busy_c3", {31'h0, busy}, 32'h0);

        // Back-to-back stream including rounding corners
        vx[0] = 32'hFFFFFFFF; vy[0] = 32'hBF800000;
        vx[1] = 32'h00000000; vy[1] = 32'h00000000;
        vx[2] = 32'h80000000; vy[2] = 32'hCF000000;
        vx[3] = 32'h01000001; vy[3] = 32'h4B800000;
        vx[4] = 32'h7FFFFFFF; vy[4] = 32'h4F000000;
        vx[5] = 32'd100;      vy[5] = 32'h42C80000;
        for (int c = 0; c < 8; c++) begin
            step();
            if (c < 6) offer(vx[c], 5'(10 + c));
            else idle_inputs();
            #1;
            if (c < 6) check($sformatf("b2b_ready%0d", c), {31'h0, in_ready}, 32'h1);
            if (c >= 2) begin
                check($sformatf("b2b_valid%0d", c), {31'h0, out_valid}, 32'h1);
                check($sformatf("b2b_y%0d", c), out_y, vy[c-2]);
                check($sformatf("b2b_tag%0d", c), {27'h0, out_tag}, 32'(10 + c - 2));
            end
        end
        step();
        idle_inputs();
        #1;
        check("b2b_drain", {31'h0, busy}, 32'h0);

        // Backpressure: two accepted, third waits, all delivered in order
        step();
        out_ready = 1'b0;
        offer(32'd2, 5'd20);
        #1;
        check("bp_ready_a", {31'h0, in_ready}, 32'h1);
        step();
        offer(32'hFFFFFFFE, 5'd21);
        #1;
        check("bp_ready_b", {31'h0, in_ready}, 32'h1);
        step();
        offer(32'd3, 5'd22);
        #1;
        check("bp_ready_c", {31'h0, in_ready}, 32'h0);
        check("bp_valid", {31'h0, out_valid}, 32'h1);
        check("bp_y_a", out_y, 32'h40000000);
        step();
        #1;
        check("bp_hold_ready", {31'h0, in_ready}, 32'h0);
        check("bp_hold_y", out_y, 32'h40000000);
        check("bp_hold_tag", {27'h0, out_tag}, 32'd20);
        check("bp_hold_cvt_x", cvt_x, 32'hFFFFFFFE);
        step();
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'h0, in_ready}, 32'h1);
        step();
        idle_inputs();
        #1;
        check("bp_y_b", out_y, 32'hC0000000);
        check("bp_tag_b", {27'h0, out_tag}, 32'd21);
        step();
        #1;
        check("bp_y_c", out_y, 32'h40400000);
        check("bp_tag_c", {27'h0, out_tag}, 32'd22);
        step();
        #1;
        check("bp_no_dup", {31'h0, out_valid}, 32'h0);
        check("bp_busy", {31'h0, busy}, 32'h0);

        // Flush with both stages full and a request on offer
        step();
        out_ready = 1'b0;
        offer(32'd4, 5'd24);
        step();
        offer(32'd5, 5'd25);
        step();
        offer(32'd6, 5'd26);
        flush = 1'b1;
        #1;
        check("fl_ready", {31'h0, in_ready}, 32'h0);
        step();
        idle_inputs();
        out_ready = 1'b1;
        #1;
        check("fl_valid", {31'h0, out_valid}, 32'h0);
        check("fl_busy", {31'h0, busy}, 32'h0);
        check("fl_y_kept", out_y, 32'h40800000);
        check("fl_tag_kept", {27'h0, out_tag}, 32'd24);
        for (int c = 0; c < 3; c++) begin
            step();
            #1;
            check($sformatf("fl_quiet%0d", c), {31'h0, out_valid}, 32'h0);
        end

        // Reset mid-operation with both stages full
        out_ready = 1'b0;
        offer(32'd7, 5'd27);
        step();
        offer(32'd8, 5'd28);
        step();
        idle_inputs();
        rstn  = 1'b0;
        flush = 1'b0;
        #1;
        check("mr_in_ready", {31'h0, in_ready}, 32'h0);
        step();
        rstn      = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mr_valid", {31'h0, out_valid}, 32'h0);
        check("mr_y", out_y, 32'h0);
        check("mr_tag", {27'h0, out_tag}, 32'h0);
        check("mr_busy", {31'h0, busy}, 32'h0);
        check("mr_cvt_x", cvt_x, 32'h0);
`ifdef FPU_CVT_STATS_EN
        check("mr_stat", {16'h0, stat_count}, 32'h0);
`endif
        step();
        #1;
        check("mr_quiet", {31'h0, out_valid}, 32'h0);

`ifdef FPU_CVT_STATS_EN
        // Three transfers, then a long stream to saturation
        for (int c = 0; c < 3; c++) begin
            step();
            offer(32'(c), 5'(c));
        end
        step();
        idle_inputs();
        step();
        step();
        #1;
        check("st_three", {16'h0, stat_count}, 32'd3);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("st_flush_keeps", {16'h0, stat_count}, 32'd3);
        offer(32'd1, 5'd1);
        for (int c = 0; c < 70000; c++) step();
        idle_inputs();
        step();
        step();
        #1;
        check("st_sat", {16'h0, stat_count}, 32'hFFFF);
        for (int c = 0; c < 5; c++) begin
            step();
            offer(32'd9, 5'd9);
        end
        step();
        idle_inputs();
        step();
        step();
        #1;
        check("st_sat_hold", {16'h0, stat_count}, 32'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
